// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared constants for the pipeline control unit: stop/no-stop levels, reset
// level, exception codes, FSM state encoding and the stall vector patterns.
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Generic levels
  localparam logic        STOP       = 1'b1;
  localparam logic        NO_STOP    = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  // This block resets when rst is low
  localparam logic        RST_ENABLE = 1'b0;

  // Exception codes delivered by the MEM stage
  localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXC_INVALID   = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

  // Control FSM states
  typedef enum logic [0:0] {
    PCTRL_RUN   = 1'b0,
    PCTRL_FLUSH = 1'b1
  } pctrl_state_e;

  // Stall vector bit order: {wb, mem, ex, id, if, pc}
  localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = {6{STOP}};

  // Stage-priority encoder: the deepest requesting stage wins, and every
  // stage upstream of it is frozen too so nothing overtakes the bubble.
  function automatic logic [5:0] encode_stall(
    input logic req_if,
    input logic req_id,
    input logic req_ex,
    input logic req_mem
  );
    logic [5:0] v;
    if (req_mem)     v = STALL_MEM;
    else if (req_ex) v = STALL_EX;
    else if (req_id) v = STALL_ID;
    else if (req_if) v = STALL_IF;
    else             v = STALL_NONE;
    return v;
  endfunction

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_stall_wdog.sv
// ----------------------------------------------------------------------------
// stall_wdog
// Saturating consecutive-stall counter with a sticky timeout flag. The count
// clears on any unstalled cycle; the flag sets on the edge where the count
// reaches STALL_TIMEOUT and holds until reset.
// ----------------------------------------------------------------------------
module stall_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int TMR_W         = 16,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stall_active,
  output logic o_timeout
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(STALL_TIMEOUT);

  logic [TMR_W-1:0] r_cnt;
  logic             r_timeout;
  logic [TMR_W-1:0] w_cnt_next;

  // Next count: clear when idle, otherwise step and saturate at LIMIT
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_cnt_next = '0;
    if (i_stall_active) begin
      if (r_cnt == LIMIT) w_cnt_next = r_cnt;
      else                w_cnt_next = r_cnt + TMR_W'(1);
    end
  end

  // Counter and sticky flag registers
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst == RST_ENABLE) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_cnt_next == LIMIT) r_timeout <= 1'b1;
    end
  end

  assign o_timeout = r_timeout;

endmodule : stall_wdog

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline control unit. Encodes stage stall requests into the 6-bit stall
// vector, sequences exceptions as one freeze cycle followed by one
// flush+redirect cycle, and runs a consecutive-stall watchdog.
// Optional build macro: PIPE_CTRL_PERF_EN enables the stall-cycle and
// flush-count performance counters; without it both outputs read zero.
// ----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          TMR_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
);

  pctrl_state_e r_state;
  pctrl_state_e w_next_state;

  logic        r_flush;
  logic [31:0] r_new_pc;

  logic [5:0]  w_stall;
  logic        w_exc_take;
  logic        w_exc_pending;
  logic [31:0] w_target;
  logic        w_stall_active;

  assign w_exc_pending  = (excepttype_i != ZERO_WORD);
  // eret returns to the saved EPC; every other exception enters the handler
  assign w_target       = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
  assign w_stall_active = (w_stall != STALL_NONE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) r_state <= PCTRL_RUN;
    else                   r_state <= w_next_state;
  end

  // FSM next-state logic: an exception in RUN always leads to one FLUSH cycle
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      PCTRL_RUN:   if (w_exc_pending) w_next_state = PCTRL_FLUSH;
      PCTRL_FLUSH: w_next_state = PCTRL_RUN;
      default:     w_next_state = PCTRL_RUN;
    endcase
  end

  // FSM outputs: stall vector and exception acceptance
  always_comb begin
    w_stall    = STALL_NONE;
    w_exc_take = 1'b0;
    unique case (r_state)
      PCTRL_RUN: begin
        if (w_exc_pending) begin
          // Freeze everything, including WB, so the faulting instruction
          // cannot commit while the redirect is prepared.
          w_stall    = STALL_ALL;
          w_exc_take = 1'b1;
        end else begin
          w_stall = encode_stall(stallreq_from_if, stallreq_from_id,
                                 stallreq_from_ex, stallreq_from_mem);
        end
      end
      // During FLUSH the pipeline registers are being cleared, so requests
      // and exceptions from the stale contents are ignored.
      PCTRL_FLUSH: w_stall = STALL_NONE;
      default:     w_stall = STALL_NONE;
    endcase
  end

  // Registered flush pulse and redirect target
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_flush  <= 1'b0;
      r_new_pc <= ZERO_WORD;
    end else begin
      r_flush <= w_exc_take;
      // new_pc is only updated on capture; downstream gates it with flush
      if (w_exc_take) r_new_pc <= w_target;
    end
  end

  assign stall  = w_stall;
  assign flush  = r_flush;
  assign new_pc = r_new_pc;

  stall_wdog #(
    .TMR_W         (TMR_W),
    .STALL_TIMEOUT (STALL_TIMEOUT)
  ) u_stall_wdog (
    .clk            (clk),
    .rst            (rst),
    .i_stall_active (w_stall_active),
    .o_timeout      (stall_timeout)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  // Performance counters: stalled cycles (freeze cycles included) and
  // FLUSH entries, both wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_stall_cycles <= ZERO_WORD;
      r_flush_count  <= ZERO_WORD;
    end else begin
      if (w_stall_active) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_exc_take)     r_flush_count  <= r_flush_count + 32'd1;
    end
  end

  assign stall_cycles_o = r_stall_cycles;
  assign flush_count_o  = r_flush_count;
`else
  assign stall_cycles_o = ZERO_WORD;
  assign flush_count_o  = ZERO_WORD;
`endif

endmodule : pipe_ctrl

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit; the producer of the 6-bit `stall` vector consumed by every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb).
- Collects stall requests from the IF, ID, EX and MEM stages and encodes them into the `stall` vector by stage priority.
- Sequences exception flushes through a small FSM: freeze, then flush plus redirect.
- Contains a consecutive-stall watchdog.

Parameters:
- EXC_VECTOR, 32'h0000_0020, redirect PC for every exception except eret.
- STALL_TIMEOUT, 1024, consecutive stalled cycles before `stall_timeout` asserts; legal range 2..65535.
- TMR_W, 16, width of the watchdog counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- stallreq_from_if  in  1  IF stage waiting on the instruction bus.
- stallreq_from_id  in  1  ID stage load-use hazard.
- stallreq_from_ex  in  1  EX stage multi-cycle operation busy.
- stallreq_from_mem  in  1  MEM stage waiting on the data bus.
- excepttype_i  in  32  exception code from MEM; 0 means none.
- cp0_epc_i  in  32  EPC from CP0, used for eret.
- stall  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = Stop.
- flush  out  1  clears all pipeline registers this cycle.
- new_pc  out  32  redirect target; valid only while flush=1.
- stall_timeout  out  1  sticky watchdog flag.
- stall_cycles_o  out  32  perf counter (see Optional Feature).
- flush_count_o  out  32  perf counter (see Optional Feature).

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=RUN; flush=0, new_pc=0, stall_timeout=0, counters=0.
  - stall=0 while state=RUN and there are no requests.
- States:
  - RUN:
    - If excepttype_i!=0: stall=6'b111111 combinationally, freezing WB so the faulting instruction does not commit.
    - Capture the target: cp0_epc_i if excepttype_i==32'h0000_000e (eret), else EXC_VECTOR.
    - Next state FLUSH.
    - Otherwise stall is combinational from the requests, highest wins:
      - mem -> 6'b011111
      - ex -> 6'b001111
      - id -> 6'b000111
      - if -> 6'b000011
      - none -> 6'b000000
  - FLUSH (exactly 1 cycle):
    - flush=1 and new_pc=captured target, both registered outputs.
    - stall=0; all stall requests and excepttype_i are ignored.
    - Next state RUN.
- Latency: exception seen at cycle T -> flush=1 at T+1 -> normal issue from new_pc at T+2.
- An exception in RUN overrides any simultaneous stall request.
- Back-to-back exceptions: a second exception arriving in the cycle after FLUSH is handled normally (freeze, then flush).
- Watchdog:
  - The counter increments each cycle stall!=0 and clears on any cycle stall==0.
  - It saturates at STALL_TIMEOUT.
  - When it reaches STALL_TIMEOUT, stall_timeout goes to 1 and stays 1 until reset.
- Reset mid-operation: a reset in FLUSH cancels the redirect; flush=0 on the following cycle.
- new_pc holds its last value when flush=0; downstream logic must gate it with flush.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cycles_o counts cycles with stall!=0.
  - flush_count_o counts FLUSH entries.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- Undefined: both outputs are tied to 32'h0 and no counter registers are built.

Decomposition:
- defines1.v holds the shared constants:
  - Stop/NoStop, ZeroWord, RstEnable, which for this block is 1'b0.
  - Exception codes: 32'h1 interrupt, 32'h8 syscall, 32'ha invalid instruction, 32'hc overflow, 32'hd trap, 32'he eret.
  - State encodings PCTRL_RUN and PCTRL_FLUSH.
- One sub-module: stall_wdog, a saturating consecutive-cycle counter with a sticky flag, parameterised by TMR_W and STALL_TIMEOUT.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all requests =1 -> after release with requests =0: stall=0, flush=0, stall_timeout=0.
- Stall priority:
  - id=1 and if=1 -> stall=6'b000111.
  - Add mem=1 -> 6'b011111.
  - Drop all -> 6'b000000 in the same cycle.
- Syscall: excepttype_i=32'h8 at T together with ex=1:
  - T: stall=6'b111111.
  - T+1: flush=1, new_pc=32'h20, stall=0.
  - T+2: flush=0.
- Eret: excepttype_i=32'he with cp0_epc_i=32'hbfc0_0100 -> at T+1 new_pc=32'hbfc0_0100, flush=1.
- Watchdog: STALL_TIMEOUT=4; hold mem=1 for 3 cycles, release 1 cycle, then hold for 4 cycles:
  - stall_timeout first rises after the 4th consecutive stalled cycle.
  - It stays 1 after the requests drop.
- Perf (PIPE_CTRL_PERF_EN defined): 10 stalled cycles plus 2 exceptions -> stall_cycles_o=12 (each freeze cycle counts), flush_count_o=2. Without the macro, both read 0.
